// File: rtl/full_adder_bit.sv
// One-bit full adder used as the arithmetic core of the serial summator.
// Ports: a, b, cin -> s (sum bit), cout (majority carry).
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/summator.sv
// Bit-serial adder with optional framing into a parallel result.
// Ports: clk, rst (sync, active-high), r1/r2 serial operands LSB first,
//        start frame pulse, sum serial out, result/busy/done frame status.
module summator #(
    parameter int reglength = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               r1,
    input  logic               r2,
    input  logic               start,
    output logic               sum,
    output logic [reglength:0] result,
    output logic               busy,
    output logic               done
);

    localparam int CW = (reglength > 0) ? $clog2(reglength + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(reglength);

    logic               sum_q;
    logic               carry_q;
    logic [reglength:0] shift_q, shift_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [reglength:0] result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic          c, s, cout;
    logic [CW-1:0] idx;
    logic          active;

    // A frame's first bit never inherits the previous carry.
    assign c = start ? 1'b0 : carry_q;

    full_adder_bit u_fa (
        .a    (r1),
        .b    (r2),
        .cin  (c),
        .s    (s),
        .cout (cout)
    );

    // Index of the bit sampled this cycle; start forces a fresh frame.
    assign idx    = start ? '0 : cnt_q;
    assign active = start | busy_q;

    // MSB-in, shift right: after reglength+1 bits, bit i holds sum bit i.
    assign shift_d = {s, shift_q[reglength:1]};

    always_comb begin
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (active) begin
            if (idx == LAST) begin
                result_d = shift_d;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = '0;
            end else begin
                cnt_d  = idx + CW'(1);
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q    <= 1'b0;
            carry_q  <= 1'b0;
            shift_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            sum_q    <= s;
            carry_q  <= cout;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sum    = sum_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_summator.sv
// Self-checking bench for summator (reglength = 3).
// Arithmetic reference model plus directed literal checks.
module tb_summator;

    localparam int RL = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r1 = 1'b0;
    logic          r2 = 1'b0;
    logic          start = 1'b0;
    logic          sum;
    logic [RL:0]   result;
    logic          busy;
    logic          done;

    summator #(.reglength(RL)) dut (
        .clk    (clk),
        .rst    (rst),
        .r1     (r1),
        .r2     (r2),
        .start  (start),
        .sum    (sum),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ndone = 0;
    bit chk_en = 1'b0;

    // Reference model: the serial stream since the last start/reset is the
    // binary expansion of A+B, where A and B are the accumulated operands.
    longint a_acc = 0;
    longint b_acc = 0;
    int     k = 0;
    bit     fr = 1'b0;
    logic          exp_sum = 1'b0;
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    logic [RL:0]   exp_result = '0;

    logic          last_sum;
    logic [3:0]    svec;
    logic [RL:0]   resv;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rs, input logic st, input logic x, input logic y);
        longint t;
        @(negedge clk);
        last_sum = sum;
        rst = rs; start = st; r1 = x; r2 = y;
        if (rs) begin
            a_acc = 0; b_acc = 0; k = 0; fr = 1'b0;
            exp_sum = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_result = '0;
        end else begin
            if (st) begin
                a_acc = 0; b_acc = 0; k = 0; fr = 1'b1;
            end
            a_acc = a_acc | (longint'(x) << k);
            b_acc = b_acc | (longint'(y) << k);
            t = a_acc + b_acc;
            exp_sum = ((t >> k) & 1) != 0;
            exp_done = 1'b0;
            if (fr && k == RL) begin
                exp_result = (RL+1)'(t);
                exp_done = 1'b1;
                fr = 1'b0;
            end
            exp_busy = fr;
            k++;
        end
        chk_en = 1'b1;
    endtask

    // Framed addition of 3-bit operands: bit RL is the carry-out slot.
    task automatic frame(input int a, input int b, input int ntrail);
        for (int i = 0; i <= RL; i++) begin
            step(1'b0, i == 0, i < RL ? a[i] : 1'b0, i < RL ? b[i] : 1'b0);
            if (i > 0) svec[i-1] = last_sum;
        end
        for (int j = 0; j < ntrail; j++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (j == 0) begin
                svec[RL] = last_sum;
                resv = result;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("model_sum", int'(sum), int'(exp_sum));
            chk("model_busy", int'(busy), int'(exp_busy));
            chk("model_done", int'(done), int'(exp_done));
            chk("model_result", int'(result), int'(exp_result));
            if (done) ndone++;
        end
    end

    initial begin
        int d0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Free-running 7+1: carry flushes out as bit 3.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("free_flush_bit3", int'(last_sum), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("free_after_flush", int'(last_sum), 0);
        chk("free_no_done", ndone, 0);

        // 5+3
        d0 = ndone;
        frame(5, 3, 2);
        chk("5p3_sum", int'(svec), 4'b1000);
        chk("5p3_result", int'(resv), 4'b1000);
        chk("5p3_done", ndone - d0, 1);

        // 7+7
        frame(7, 7, 2);
        chk("7p7_sum", int'(svec), 4'b1110);
        chk("7p7_result", int'(resv), 4'b1110);

        // 0+0 still pulses done
        d0 = ndone;
        frame(0, 0, 2);
        chk("0p0_result", int'(resv), 0);
        chk("0p0_done", ndone - d0, 1);

        // Frame 15+1 leaves carry 1 pending; next start ignores it.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        frame(1, 0, 2);
        chk("carry_ignored", int'(resv), 4'b0001);

        // Restart while busy: abandoned frame gives no done.
        d0 = ndone;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        frame(2, 2, 2);
        chk("restart_result", int'(resv), 4);
        chk("restart_done", ndone - d0, 1);

        // Reset at bit 2 of a frame.
        d0 = ndone;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_no_done", ndone - d0, 0);
        frame(2, 1, 2);
        chk("post_rst_result", int'(resv), 3);

        // Exhaustive sweep with four trailing zeros.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                frame(a, b, 4);
                chk("sweep", int'(resv), a + b);
            end
        end

        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/summator.md
SUMMATOR -- requirements
Module: summator

Interface
REQ-001 SHALL have parameter reglength, default 3, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port r1, input, 1 bit: serial operand A, LSB first, one bit per clock.
REQ-005 SHALL have port r2, input, 1 bit: serial operand B, LSB first, one bit per clock.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse marking the cycle carrying bit 0 of both operands; tie low for free-running use.
REQ-007 SHALL have port sum, output, 1 bit: registered serial sum bit.
REQ-008 SHALL have port result, output, reglength+1 bits: parallel sum of the last frame.
REQ-009 SHALL have port busy, output, 1 bit: high while a framed addition is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when result is updated.

Function
REQ-011 SHALL be a bit-serial full adder: each rising edge, sum <= r1 ^ r2 ^ c, where c is the carry used in that cycle.
REQ-012 SHALL, on the same edge, set the carry flip-flop to the majority of r1, r2 and c.
REQ-013 SHALL use c = 0 in a cycle where start = 1; otherwise c is the carry flip-flop.
REQ-014 SHALL give a one-cycle latency: the sum bit for input bit k appears on sum after the edge that sampled bit k.
REQ-015 SHALL, when start is never asserted, run free: the carry propagates continuously, and trailing zero inputs flush a pending carry out as a final 1 bit, after which the carry is 0.
REQ-016 SHALL, on start, clear a bit counter to 0, shift the new sum bit into an internal shift register, and assert busy from the next cycle.
REQ-017 SHALL count sampled bits from 0 to reglength; the bit sampled at count reglength is the carry-out bit, and operand bits there are expected to be 0.
REQ-018 SHALL fill the shift register MSB-in, shifting right, so that after reglength+1 bits bit i holds sum bit i.
REQ-019 SHALL, after the edge sampling bit reglength: load result from the shift register, pulse done for exactly one cycle, and deassert busy.
REQ-020 SHALL hold result stable between done pulses.
REQ-021 SHALL, if start is asserted while busy, abandon the current frame without a done pulse and start a new frame in that cycle.
REQ-022 SHALL give result the width reglength+1, so that the maximum (2^reglength-1)*2 fits without overflow.

Reset
REQ-023 SHALL, while rst = 1 on a rising edge, clear sum, carry, shift register, counter, result, busy and done to 0.
REQ-024 SHALL give rst priority over start, including mid-frame; an aborted frame produces no done pulse.
REQ-025 SHALL resume normal operation on the first edge with rst = 0.

Structure
REQ-026 SHALL be a single module with no shared package; the only constant is reglength, and the counter width is $clog2(reglength+1).
REQ-027 SHALL place the 1-bit full adder (a, b, cin -> s, cout) in a sub-module named full_adder_bit; all other logic is in summator.

Verification (reglength = 3)
REQ-028 SHALL cover A=5, B=3 (r1 1,0,1,0; r2 1,1,0,0; start on first bit) -> sum 0,0,0,1; result 4'b1000; one done pulse.
REQ-029 SHALL cover A=7, B=7 -> sum 0,1,1,1; result 4'b1110.
REQ-030 SHALL cover A=0, B=0 -> sum all 0; result 0; done still pulses.
REQ-031 SHALL cover a frame ending with carry 1 followed by start with A=1, B=0 -> the carry is ignored; result 4'b0001.
REQ-032 SHALL cover rst asserted at bit 2 of a frame -> all outputs 0 next cycle, no done; the following framed 2+1 gives result 3.
REQ-033 SHALL cover an exhaustive sweep of all 64 operand pairs, each framed with 4 trailing zero cycles -> result equals A+B for every pair.
